// File: rtl/axi_stream_skid_slice.sv
// -----------------------------------------------------------------------------
// axi_stream_skid_slice
//   Two-entry AXI4-Stream register slice. An output register (OREG) drives every
//   m_ signal directly and a skid register (SREG) catches the one beat that can
//   arrive in the cycle after the downstream stalls. Both handshake outputs are
//   flop-driven, so the slice breaks every combinational path: s_tready does not
//   depend on m_tready, and m_ outputs do not depend on s_ inputs. Full
//   throughput is sustained while m_tready is held high. Latency is one cycle.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   s_t*                : upstream AXI4-Stream slave (valid/ready/data/strb/keep/
//                         last/id/dest/user)
//   m_t*                : downstream AXI4-Stream master, same field set
// -----------------------------------------------------------------------------
module axi_stream_skid_slice #(
    parameter int byte_width = 4,
    parameter int id_width   = 1,
    parameter int dest_width = 1,
    parameter int user_width = 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [8*byte_width-1:0] s_tdata,
    input  logic [byte_width-1:0]   s_tstrb,
    input  logic [byte_width-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic [id_width-1:0]     s_tid,
    input  logic [dest_width-1:0]   s_tdest,
    input  logic [user_width-1:0]   s_tuser,

    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [8*byte_width-1:0] m_tdata,
    output logic [byte_width-1:0]   m_tstrb,
    output logic [byte_width-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic [id_width-1:0]     m_tid,
    output logic [dest_width-1:0]   m_tdest,
    output logic [user_width-1:0]   m_tuser
);

    localparam int PW = 8*byte_width + 2*byte_width + 1 + id_width + dest_width + user_width;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q, rdy_d;
    logic [PW-1:0]   oreg_q, oreg_d;
    logic [PW-1:0]   sreg_q, sreg_d;
    logic [PW-1:0]   s_payload;
    logic            acc, snd;

    assign s_payload = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = oreg_q;

    assign m_tvalid = (state_q != EMPTY);
    // Kept as its own flop rather than decoded from state: it must read 0 while
    // reset is held and only rise on the first edge after release.
    assign s_tready = rdy_q;

    assign acc = s_tvalid && rdy_q;
    assign snd = m_tvalid && m_tready;

    always_comb begin
        state_d = state_q;
        oreg_d  = oreg_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    oreg_d  = s_payload;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && snd) begin
                    oreg_d  = s_payload;
                end else if (acc) begin
                    // Downstream stalled: park the new beat behind the held one.
                    sreg_d  = s_payload;
                    state_d = FULL;
                end else if (snd) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (snd) begin
                    oreg_d  = sreg_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready for the next cycle is a function of the next state only.
        rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            oreg_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            oreg_q  <= oreg_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_skid_slice.sv
module tb_axi_stream_skid_slice;

    localparam int BW = 4;
    localparam int PW = 8*BW + 2*BW + 1 + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [31:0]   s_tdata = '0;
    logic [3:0]    s_tstrb = '0;
    logic [3:0]    s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic [0:0]    s_tid = '0;
    logic [0:0]    s_tdest = '0;
    logic [0:0]    s_tuser = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tstrb;
    logic [3:0]    m_tkeep;
    logic          m_tlast;
    logic [0:0]    m_tid;
    logic [0:0]    m_tdest;
    logic [0:0]    m_tuser;

    logic [PW-1:0] s_pl, m_pl;
    assign s_pl = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign m_pl = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

    int n_tests = 0;
    int n_fail  = 0;

    axi_stream_skid_slice #(
        .byte_width(BW), .id_width(1), .dest_width(1), .user_width(1)
    ) dut (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [PW-1:0] q[$];
        logic [PW-1:0] prev_pl;
        logic [PW-1:0] exp_pl;
        logic          stall_prev;
        logic          r0;
        int            acc_n;
        int            cyc;

        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        #1;
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_sready", s_tready, 0);
        chk("rst_payload", m_pl, 0);
        tick();
        tick();
        reset    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_0BAD;
        #1;
        chk("rel_sready_pre", s_tready, 0);
        tick();
        chk("rel_sready", s_tready, 1);
        chk("rel_no_accept", m_tvalid, 0);
        s_tvalid = 1'b0;

        // ---------------- streaming ----------------
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(i);
            s_tlast  = (i == 8);
            tick();
            chk("str_mvalid", m_tvalid, 1);
            chk("str_data", m_tdata, 64'(i));
            chk("str_last", m_tlast, (i == 8) ? 1 : 0);
            chk("str_sready", s_tready, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        chk("str_drain", m_tvalid, 0);

        // ---------------- backpressure ----------------
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hA5A5_A5A5;
        tick();
        chk("bp_one_sready", s_tready, 1);
        chk("bp_one_data", m_tdata, 64'hA5A5_A5A5);
        s_tdata = 32'h5A5A_5A5A;
        tick();
        chk("bp_full_sready", s_tready, 0);
        chk("bp_full_mvalid", m_tvalid, 1);
        chk("bp_full_data", m_tdata, 64'hA5A5_A5A5);
        s_tdata = 32'hDEAD_BEEF;       // ignored while s_tready is low
        tick();
        chk("bp_hold_sready", s_tready, 0);
        chk("bp_hold_data", m_tdata, 64'hA5A5_A5A5);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        chk("bp_rel_data", m_tdata, 64'h5A5A_5A5A);
        chk("bp_rel_sready", s_tready, 1);
        tick();
        chk("bp_drain", m_tvalid, 0);

        // ---------------- sideband ----------------
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h1234_5678;
        s_tid    = 1'b1;
        s_tdest  = 1'b1;
        s_tuser  = 1'b1;
        s_tkeep  = 4'hF;
        s_tstrb  = 4'h3;
        s_tlast  = 1'b1;
        tick();
        s_tvalid = 1'b0;
        chk("sb_data", m_tdata, 64'h1234_5678);
        chk("sb_id", m_tid, 1);
        chk("sb_dest", m_tdest, 1);
        chk("sb_user", m_tuser, 1);
        chk("sb_keep", m_tkeep, 4'hF);
        chk("sb_strb", m_tstrb, 4'h3);
        chk("sb_last", m_tlast, 1);
        m_tready = 1'b1;
        tick();
        chk("sb_drain", m_tvalid, 0);

        // ---------------- random traffic with scoreboard ----------------
        acc_n      = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        prev_pl    = '0;
        while ((acc_n < 10000 || q.size() != 0) && cyc < 60000) begin
            s_tvalid = (acc_n < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_tdata  = $urandom;
            s_tstrb  = 4'($urandom);
            s_tkeep  = 4'($urandom);
            s_tlast  = 1'($urandom);
            s_tid    = 1'($urandom);
            s_tdest  = 1'($urandom);
            s_tuser  = 1'($urandom);
            m_tready = 1'($urandom_range(0, 1));
            r0 = s_tready;
            // s_tready must not move when m_tready toggles within a cycle.
            m_tready = ~m_tready;
            #1;
            chk("rnd_rdy_indep", s_tready, r0);
            m_tready = ~m_tready;
            #1;
            if (stall_prev) begin
                chk("rnd_hold_vld", m_tvalid, 1);
                chk("rnd_hold_pl", m_pl, prev_pl);
            end
            if (s_tvalid && s_tready) begin
                q.push_back(s_pl);
                acc_n++;
            end
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    chk("rnd_underflow", 1, 0);
                end else begin
                    exp_pl = q.pop_front();
                    chk("rnd_beat", m_pl, exp_pl);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_pl    = m_pl;
            tick();
            cyc++;
        end
        chk("rnd_complete", (cyc < 60000) ? 1 : 0, 1);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        chk("rnd_drain", m_tvalid, 0);

        // ---------------- reset mid-operation ----------------
        m_tready = 1'b0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_0011;
        tick();
        s_tdata = 32'h0000_0022;
        tick();
        chk("mr_full_sready", s_tready, 0);
        chk("mr_full_mvalid", m_tvalid, 1);
        s_tvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mr_mvalid", m_tvalid, 0);
        chk("mr_sready", s_tready, 0);
        chk("mr_data", m_tdata, 0);
        #1 reset = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_0077;
        tick();
        chk("mr_rel_sready", s_tready, 1);
        chk("mr_rel_mvalid", m_tvalid, 0);
        tick();
        chk("mr_first_vld", m_tvalid, 1);
        chk("mr_first_data", m_tdata, 64'h77);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        chk("mr_drain", m_tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_stream_skid_slice.md
AXI_STREAM_SKID_SLICE -- requirements
Module: axi_stream_skid_slice

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- byte_width, 4, TDATA bytes per beat
- id_width, 1, TID bits
- dest_width, 1, TDEST bits
- user_width, 1, TUSER bits
- All parameters SHALL be >= 1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic rising-edge.
- reset, in, 1, asynchronous active-high reset.
- s_tvalid, in, 1, upstream beat valid.
- s_tready, out, 1, slice accepts upstream beat.
- s_tdata, in, 8*byte_width, upstream data.
- s_tstrb, in, byte_width, upstream byte strobes.
- s_tkeep, in, byte_width, upstream byte keeps.
- s_tlast, in, 1, upstream packet end.
- s_tid, in, id_width, upstream stream ID.
- s_tdest, in, dest_width, upstream routing.
- s_tuser, in, user_width, upstream sideband.
- m_tvalid, m_tready, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser: mirror of the s_ set, same widths, opposite directions; downstream AXI4-Stream master.

REQ-003 The block SHALL have one clock (clk); reset SHALL be asynchronous and active-high (reset).

Function
REQ-004 The block SHALL be a 2-entry register slice: an output register (OREG) driving all m_ signals, plus a skid register (SREG).
- Payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}.

REQ-005 States SHALL be:
- EMPTY: OREG and SREG invalid.
- ONE: OREG valid, SREG invalid.
- FULL: both valid.

REQ-006 Outputs SHALL be:
- m_tvalid = 1 in ONE or FULL.
- s_tready = 1 in EMPTY or ONE.
- s_tready SHALL come from a register only; no combinational path from m_tready or any s_ input to s_tready.
- No combinational path from any s_ input to any m_ output.

REQ-007 Transitions (acc = s_tvalid && s_tready; snd = m_tvalid && m_tready):
- EMPTY, acc: load OREG, go to ONE.
- ONE, acc && snd: load OREG, stay ONE.
- ONE, acc && !snd: load SREG, go to FULL.
- ONE, !acc && snd: go to EMPTY.
- FULL, snd: move SREG to OREG, go to ONE.
- Otherwise: hold state.

REQ-008 Latency SHALL be 1 cycle: a beat accepted at edge N is presented on m_ after edge N.

REQ-009 Throughput SHALL be 1 beat/cycle while m_tready is held high.

REQ-010 Beats SHALL leave in acceptance order.
- No beat SHALL be dropped, duplicated or modified.
- Every payload field SHALL be delivered bit-exact.

REQ-011 While m_tvalid && !m_tready, every m_ payload signal SHALL remain stable and m_tvalid SHALL remain high.

REQ-012 The block SHALL NOT check or alter tkeep/tstrb legality; it passes them through unchanged.

REQ-013 s_ inputs SHALL be ignored when s_tready is low.

Reset
REQ-014 While reset is high:
- State SHALL be EMPTY, with m_tvalid = 0 and s_tready = 0.
- All payload registers SHALL be zero.
- Assertion takes effect immediately, independent of clk.

REQ-015 On the first rising clk edge after reset deasserts, s_tready SHALL become 1.
- Beats presented before that edge SHALL NOT be accepted.

REQ-016 Reset asserted mid-transfer (ONE or FULL) SHALL discard all held beats.
- No partial beat SHALL appear on m_ after reset.

REQ-017 m_ outputs SHALL satisfy the team's AXI-Stream master formal property set under every input sequence, with reset mapped to !resetn.

Verification
REQ-018 Streaming: m_tready = 1; send tdata 0x00000001..0x00000008 back-to-back, last beat tlast = 1 -> same 8 words on m_ one cycle later, no bubbles, tlast only on word 8.

REQ-019 Backpressure: send 0xA5A5A5A5, then 0x5A5A5A5A, with m_tready = 0 -> state FULL, s_tready = 0, m_tdata held at 0xA5A5A5A5; raise m_tready -> 0xA5A5A5A5 then 0x5A5A5A5A, s_tready = 1 again one cycle after the first send.

REQ-020 Sideband: beat with tid = 1, tdest = 1, tuser = 1, tkeep = 0xF, tstrb = 0x3 -> identical values on m_ with that beat.

REQ-021 Random: random s_tvalid and m_tready (50%), 10,000 beats -> scoreboard shows exact in-order match; s_tready never depends combinationally on m_tready.

REQ-022 Reset mid-operation: state FULL, pulse reset between clk edges -> m_tvalid = 0 and s_tready = 0 immediately; after release, first accepted beat is the first on m_.
